// File: rtl/mc_ctrl_pkg.sv
// Shared types and constants for the multicycle RV32I control FSM.
// The state encoding, opcodes, mux selects and opcode-to-state dispatch all live here.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXE_R    = 4'd6,
    S_EXE_I    = 4'd7,
    S_EXE_LUI  = 4'd8,
    S_JAL      = 4'd9,
    S_EXE_JALR = 4'd10,
    S_JALR_PC  = 4'd11,
    S_ALUWB    = 4'd12,
    S_BEQ      = 4'd13,
    S_TRAP     = 4'd14
  } state_t;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT  = 2'b10;

  // auipc skips an execute state: DECODE already computed OldPC+imm into ALUOut.
  function automatic state_t decode_next(input logic [6:0] op);
    case (op)
      OP_LW, OP_SW: return S_MEMADR;
      OP_R:         return S_EXE_R;
      OP_I:         return S_EXE_I;
      OP_JAL:       return S_JAL;
      OP_BEQ:       return S_BEQ;
      OP_JALR:      return S_EXE_JALR;
      OP_LUI:       return S_EXE_LUI;
      OP_AUIPC:     return S_ALUWB;
      default:      return S_TRAP;
    endcase
  endfunction

endpackage

// File: rtl/mc_ctrl_if.sv
// Control bundle between the FSM and the datapath/memory: opcode and memory
// handshake in, mux selects and write strobes out.
interface mc_ctrl_if;
  logic [6:0] op;
  logic       mem_ready;
  logic       mem_req;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ResultSrc;
  logic [1:0] ALUOp;
  logic       AdrSrc;
  logic       PCUpdate;
  logic       Branch;
  logic       IRWrite;
  logic       RegWrite;
  logic       MemWrite;
  logic       illegal;

  modport master (
    input  op, mem_ready,
    output mem_req, ALUSrcA, ALUSrcB, ResultSrc, ALUOp, AdrSrc,
           PCUpdate, Branch, IRWrite, RegWrite, MemWrite, illegal
  );

  modport slave (
    output op, mem_ready,
    input  mem_req, ALUSrcA, ALUSrcB, ResultSrc, ALUOp, AdrSrc,
           PCUpdate, Branch, IRWrite, RegWrite, MemWrite, illegal
  );
endinterface

// File: rtl/mc_instret_ctr.sv
// Retired-instruction counter: synchronous clear, +1 on inc, wraps at 2^CNT_W.
module mc_instret_ctr #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (reset)
      count_d = '0;
    else if (inc)
      count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk) begin
    count_q <= count_d;
  end

  assign count = count_q;
endmodule

// File: rtl/mc_ctrl_fsm.sv
// Main Moore control FSM of the multicycle RV32I core with memory stalls,
// lui/auipc/jalr, illegal-opcode trap and an instret counter.
module mc_ctrl_fsm
  import mc_ctrl_pkg::*;
#(
  parameter bit MEM_HANDSHAKE = 1'b1,
  parameter bit TRAP_HALT     = 1'b0,
  parameter int CNT_W         = 32
) (
  input  logic             clk,
  input  logic             reset,
  mc_ctrl_if.master        bus,
  output logic [CNT_W-1:0] instret
);
  state_t state_q, state_d;
  logic   rdy;
  logic   retire;

  // Without the handshake the memory is assumed to answer in one cycle.
  assign rdy = bus.mem_ready | ~MEM_HANDSHAKE;

  always_ff @(posedge clk) begin
    state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    if (reset) begin
      state_d = S_FETCH;
    end else begin
      case (state_q)
        S_FETCH:    if (rdy) state_d = S_DECODE;
        S_DECODE:   state_d = decode_next(bus.op);
        S_MEMADR:   state_d = (bus.op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
        S_MEMREAD:  if (rdy) state_d = S_MEMWB;
        S_MEMWB:    begin state_d = S_FETCH; retire = 1'b1; end
        S_MEMWRITE: if (rdy) begin state_d = S_FETCH; retire = 1'b1; end
        S_EXE_R, S_EXE_I, S_EXE_LUI, S_JAL, S_JALR_PC:
                    state_d = S_ALUWB;
        S_EXE_JALR: state_d = S_JALR_PC;
        S_ALUWB:    begin state_d = S_FETCH; retire = 1'b1; end
        S_BEQ:      begin state_d = S_FETCH; retire = 1'b1; end
        S_TRAP:     state_d = TRAP_HALT ? S_TRAP : S_FETCH;
        default:    state_d = S_FETCH;
      endcase
    end
  end

  always_comb begin
    bus.mem_req   = 1'b0;
    bus.ALUSrcA   = SRCA_PC;
    bus.ALUSrcB   = SRCB_RS2;
    bus.ResultSrc = RES_ALUOUT;
    bus.ALUOp     = ALUOP_ADD;
    bus.AdrSrc    = 1'b0;
    bus.PCUpdate  = 1'b0;
    bus.Branch    = 1'b0;
    bus.IRWrite   = 1'b0;
    bus.RegWrite  = 1'b0;
    bus.MemWrite  = 1'b0;
    bus.illegal   = 1'b0;
    case (state_q)
      S_FETCH: begin
        bus.mem_req   = 1'b1;
        bus.ALUSrcB   = SRCB_FOUR;
        bus.ResultSrc = RES_ALURESULT;
        bus.IRWrite   = rdy;
        bus.PCUpdate  = rdy;
      end
      S_DECODE: begin
        bus.ALUSrcA = SRCA_OLDPC;
        bus.ALUSrcB = SRCB_IMM;
      end
      S_MEMADR, S_EXE_JALR: begin
        bus.ALUSrcA = SRCA_RS1;
        bus.ALUSrcB = SRCB_IMM;
      end
      S_MEMREAD: begin
        bus.mem_req = 1'b1;
        bus.AdrSrc  = 1'b1;
      end
      S_MEMWB: begin
        bus.ResultSrc = RES_DATA;
        bus.RegWrite  = 1'b1;
      end
      // The store is committed only in the cycle the memory accepts it.
      S_MEMWRITE: begin
        bus.mem_req  = 1'b1;
        bus.AdrSrc   = 1'b1;
        bus.MemWrite = rdy;
      end
      S_EXE_R: begin
        bus.ALUSrcA = SRCA_RS1;
        bus.ALUSrcB = SRCB_RS2;
        bus.ALUOp   = ALUOP_FUNCT;
      end
      S_EXE_I: begin
        bus.ALUSrcA = SRCA_RS1;
        bus.ALUSrcB = SRCB_IMM;
        bus.ALUOp   = ALUOP_FUNCT;
      end
      S_EXE_LUI: begin
        bus.ALUSrcA = SRCA_ZERO;
        bus.ALUSrcB = SRCB_IMM;
      end
      S_JAL, S_JALR_PC: begin
        bus.ALUSrcA   = SRCA_OLDPC;
        bus.ALUSrcB   = SRCB_FOUR;
        bus.ResultSrc = RES_ALUOUT;
        bus.PCUpdate  = 1'b1;
      end
      S_ALUWB: begin
        bus.ResultSrc = RES_ALUOUT;
        bus.RegWrite  = 1'b1;
      end
      S_BEQ: begin
        bus.ALUSrcA = SRCA_RS1;
        bus.ALUSrcB = SRCB_RS2;
        bus.ALUOp   = ALUOP_BRANCH;
        bus.Branch  = 1'b1;
      end
      S_TRAP: bus.illegal = 1'b1;
      default: ;
    endcase
    if (reset) begin
      bus.mem_req  = 1'b0;
      bus.PCUpdate = 1'b0;
      bus.Branch   = 1'b0;
      bus.IRWrite  = 1'b0;
      bus.RegWrite = 1'b0;
      bus.MemWrite = 1'b0;
      bus.illegal  = 1'b0;
    end
  end

  mc_instret_ctr #(.CNT_W(CNT_W)) u_instret (
    .clk   (clk),
    .reset (reset),
    .inc   (retire),
    .count (instret)
  );
endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Table-driven bench for mc_ctrl_fsm: one DUT with default parameters and one
// with MEM_HANDSHAKE=0, TRAP_HALT=1, CNT_W=4; outputs checked every cycle.
module tb_mc_ctrl_fsm;
  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RR = 7'b0110011;
  localparam logic [6:0] II = 7'b0010011, JAL = 7'b1101111, BEQ = 7'b1100011;
  localparam logic [6:0] JALR = 7'b1100111, LUI = 7'b0110111, AUIPC = 7'b0010111;
  localparam logic [6:0] BAD = 7'h7F;

  // {mem_req, A, B, ResultSrc, ALUOp, AdrSrc, PCUpdate, Branch, IRWrite, RegWrite, MemWrite, illegal}
  localparam logic [15:0] E_FETCH = {1'b1, 2'b00, 2'b10, 2'b10, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
  localparam logic [15:0] E_FSTL  = {1'b1, 2'b00, 2'b10, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam logic [15:0] E_DEC   = {1'b0, 2'b01, 2'b01, 2'b00, 2'b00, 7'b0};
  localparam logic [15:0] E_MADR  = {1'b0, 2'b10, 2'b01, 2'b00, 2'b00, 7'b0};
  localparam logic [15:0] E_MRD   = {1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 6'b0};
  localparam logic [15:0] E_MWB   = {1'b0, 2'b00, 2'b00, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  localparam logic [15:0] E_MWR   = {1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  localparam logic [15:0] E_EXR   = {1'b0, 2'b10, 2'b00, 2'b00, 2'b10, 7'b0};
  localparam logic [15:0] E_EXI   = {1'b0, 2'b10, 2'b01, 2'b00, 2'b10, 7'b0};
  localparam logic [15:0] E_LUI   = {1'b0, 2'b11, 2'b01, 2'b00, 2'b00, 7'b0};
  localparam logic [15:0] E_JAL   = {1'b0, 2'b01, 2'b10, 2'b00, 2'b00, 1'b0, 1'b1, 5'b0};
  localparam logic [15:0] E_AWB   = {1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  localparam logic [15:0] E_BEQ   = {1'b0, 2'b10, 2'b00, 2'b00, 2'b01, 1'b0, 1'b0, 1'b1, 4'b0};
  localparam logic [15:0] E_TRAP  = 16'h0001;
  localparam logic [15:0] E_RST   = 16'h0000;
  localparam logic [15:0] M_RST   = 16'h803F;

  typedef struct {
    bit          dut;
    bit          rst;
    logic [6:0]  op;
    bit          rdy;
    logic [15:0] exp;
    logic [15:0] mask;
    int unsigned cnt;
  } vec_t;

  vec_t tbl[$];
  int   total = 0;
  int   bad   = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_a, reset_b, rdy_a, rdy_b;
  logic [6:0]  op_a, op_b;
  logic [31:0] instret_a;
  logic [3:0]  instret_b;
  logic [15:0] out_a, out_b;

  mc_ctrl_if if_a ();
  mc_ctrl_if if_b ();

  assign if_a.op = op_a;
  assign if_a.mem_ready = rdy_a;
  assign if_b.op = op_b;
  assign if_b.mem_ready = rdy_b;

  assign out_a = {if_a.mem_req, if_a.ALUSrcA, if_a.ALUSrcB, if_a.ResultSrc, if_a.ALUOp, if_a.AdrSrc,
                  if_a.PCUpdate, if_a.Branch, if_a.IRWrite, if_a.RegWrite, if_a.MemWrite, if_a.illegal};
  assign out_b = {if_b.mem_req, if_b.ALUSrcA, if_b.ALUSrcB, if_b.ResultSrc, if_b.ALUOp, if_b.AdrSrc,
                  if_b.PCUpdate, if_b.Branch, if_b.IRWrite, if_b.RegWrite, if_b.MemWrite, if_b.illegal};

  mc_ctrl_fsm #(.MEM_HANDSHAKE(1'b1), .TRAP_HALT(1'b0), .CNT_W(32)) dut_a (
    .clk(clk), .reset(reset_a), .bus(if_a.master), .instret(instret_a)
  );

  mc_ctrl_fsm #(.MEM_HANDSHAKE(1'b0), .TRAP_HALT(1'b1), .CNT_W(4)) dut_b (
    .clk(clk), .reset(reset_b), .bus(if_b.master), .instret(instret_b)
  );

  task automatic add(input bit d, input bit r, input logic [6:0] op, input bit rdy,
                     input logic [15:0] exp, input int unsigned cnt);
    vec_t v;
    v.dut = d; v.rst = r; v.op = op; v.rdy = rdy; v.exp = exp;
    v.mask = r ? M_RST : 16'hFFFF;
    v.cnt = cnt;
    tbl.push_back(v);
  endtask

  // FETCH, DECODE, one execute state, ALUWB.
  task automatic add_alu(input bit d, input logic [6:0] op, input bit rdy,
                         input logic [15:0] exe, input int unsigned cnt);
    add(d, 0, op, rdy, E_FETCH, cnt);
    add(d, 0, op, rdy, E_DEC, cnt);
    add(d, 0, op, rdy, exe, cnt);
    add(d, 0, op, rdy, E_AWB, cnt);
  endtask

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input vec_t v, input int idx);
    if (!v.dut) begin
      reset_a = v.rst; op_a = v.op; rdy_a = v.rdy;
    end else begin
      reset_b = v.rst; op_b = v.op; rdy_b = v.rdy;
    end
    #1;
    if (!v.dut) begin
      check_output($sformatf("vec%0d_a_ctl", idx), {16'h0, out_a & v.mask}, {16'h0, v.exp & v.mask});
      check_output($sformatf("vec%0d_a_instret", idx), instret_a, v.cnt);
    end else begin
      check_output($sformatf("vec%0d_b_ctl", idx), {16'h0, out_b & v.mask}, {16'h0, v.exp & v.mask});
      check_output($sformatf("vec%0d_b_instret", idx), {28'h0, instret_b}, v.cnt);
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL timeout");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    reset_a = 1'b1; reset_b = 1'b1;
    op_a = LW; op_b = LW; rdy_a = 1'b0; rdy_b = 1'b0;

    // DUT A: lw with 2 fetch stalls and 3 read stalls; RegWrite lands on cycle 10
    add(0, 0, LW, 0, E_FSTL, 0);
    add(0, 0, LW, 0, E_FSTL, 0);
    add(0, 0, LW, 1, E_FETCH, 0);
    add(0, 0, LW, 0, E_DEC, 0);
    add(0, 0, LW, 1, E_MADR, 0);
    add(0, 0, LW, 0, E_MRD, 0);
    add(0, 0, LW, 0, E_MRD, 0);
    add(0, 0, LW, 0, E_MRD, 0);
    add(0, 0, LW, 1, E_MRD, 0);
    add(0, 0, LW, 0, E_MWB, 0);
    // sw with one write stall: MemWrite only in the accepting cycle
    add(0, 0, SW, 1, E_FETCH, 1);
    add(0, 0, SW, 1, E_DEC, 1);
    add(0, 0, SW, 1, E_MADR, 1);
    add(0, 0, SW, 0, E_FSTL & 16'h0 | E_MRD, 1);
    add(0, 0, SW, 1, E_MWR, 1);
    add_alu(0, RR, 1, E_EXR, 2);
    add_alu(0, II, 1, E_EXI, 3);
    add_alu(0, LUI, 1, E_LUI, 4);
    add(0, 0, AUIPC, 1, E_FETCH, 5);
    add(0, 0, AUIPC, 1, E_DEC, 5);
    add(0, 0, AUIPC, 1, E_AWB, 5);
    add_alu(0, JAL, 1, E_JAL, 6);
    // jalr: EXE_JALR, JALR_PC, ALUWB
    add(0, 0, JALR, 1, E_FETCH, 7);
    add(0, 0, JALR, 1, E_DEC, 7);
    add(0, 0, JALR, 1, E_MADR, 7);
    add(0, 0, JALR, 1, E_JAL, 7);
    add(0, 0, JALR, 1, E_AWB, 7);
    add(0, 0, BEQ, 1, E_FETCH, 8);
    add(0, 0, BEQ, 1, E_DEC, 8);
    add(0, 0, BEQ, 1, E_BEQ, 8);
    // illegal opcode: one trap cycle, then FETCH with instret unchanged
    add(0, 0, BAD, 1, E_FETCH, 9);
    add(0, 0, BAD, 1, E_DEC, 9);
    add(0, 0, BAD, 1, E_TRAP, 9);
    add(0, 0, SW, 1, E_FETCH, 9);
    add(0, 0, SW, 1, E_DEC, 9);
    add(0, 0, SW, 1, E_MADR, 9);

    // DUT B: no handshake, mem_ready held low throughout
    add(1, 1, LW, 0, E_RST, 0);
    add(1, 0, LW, 0, E_FETCH, 0);
    add(1, 0, LW, 0, E_DEC, 0);
    add(1, 0, LW, 0, E_MADR, 0);
    add(1, 0, LW, 0, E_MRD, 0);
    add(1, 0, LW, 0, E_MWB, 0);
    add(1, 0, SW, 0, E_FETCH, 1);
    add(1, 0, SW, 0, E_DEC, 1);
    add(1, 0, SW, 0, E_MADR, 1);
    add(1, 0, SW, 0, E_MWR, 1);
    add_alu(1, RR, 0, E_EXR, 2);
    add(1, 0, BEQ, 0, E_FETCH, 3);
    add(1, 0, BEQ, 0, E_DEC, 3);
    add(1, 0, BEQ, 0, E_BEQ, 3);
    add(1, 1, II, 0, E_RST, 4);
    for (int k = 0; k < 16; k++) add_alu(1, II, 0, E_EXI, k);
    add(1, 0, BAD, 0, E_FETCH, 0);
    add(1, 0, BAD, 0, E_DEC, 0);
    for (int k = 0; k < 4; k++) add(1, 0, BAD, 0, E_TRAP, 0);
    add(1, 1, BAD, 0, E_RST, 0);
    add(1, 0, BAD, 0, E_FETCH, 0);

    repeat (2) @(negedge clk);
    check_output("reset_a_strobes", {16'h0, out_a & M_RST}, 32'h0);
    check_output("reset_a_instret", instret_a, 32'h0);
    reset_a = 1'b0;

    // Only the DUT A half of the table; B's half runs after the reset sequence.
    for (int i = 0; i < tbl.size(); i++) begin
      if (!tbl[i].dut) apply_stimulus(tbl[i], i);
    end

    // Reset lands while DUT A sits in MEMWRITE with mem_ready=1.
    reset_a = 1'b1; rdy_a = 1'b1; op_a = SW;
    #1;
    check_output("rst_memwrite_memwrite", {31'h0, if_a.MemWrite}, 32'h0);
    check_output("rst_memwrite_memreq", {31'h0, if_a.mem_req}, 32'h0);
    check_output("rst_memwrite_instret_before", instret_a, 32'd9);
    @(negedge clk);
    reset_a = 1'b0;
    #1;
    check_output("rst_memwrite_fetch", {16'h0, out_a}, {16'h0, E_FETCH});
    check_output("rst_memwrite_instret_after", instret_a, 32'h0);
    @(negedge clk);

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].dut) apply_stimulus(tbl[i], i);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
